// File: rtl/dff_pkg.sv
// Shared defaults and sizing helper for the dff_pipeline delay line.
package dff_pkg;

    localparam int DFF_DEF_WIDTH = 8;
    localparam int DFF_DEF_DEPTH = 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One delay-line stage: a WIDTH-bit data register plus its valid bit.
module dff_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    // Flush drops validity only; data keeps shifting state untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else if (flush) begin
            vld_q  <= 1'b0;
        end else if (en) begin
            data_q <= d_in;
            vld_q  <= v_in;
        end
    end

    assign d_out = data_q;
    assign v_out = vld_q;

endmodule

// File: rtl/dff_pipeline.sv
// DEPTH-stage registered delay line with per-stage valid, stall, flush
// and a registered count of valid items in flight.
module dff_pipeline
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEF_WIDTH,
    parameter int               DEPTH     = DFF_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    // Index 0 is the input; index i+1 is the output of stage i.
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH:0]            vld;
    logic [OCC_W-1:0]          occ_q, occ_d;

    assign dat[0] = d;
    assign vld[0] = d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .flush (flush),
            .d_in  (dat[i]),
            .v_in  (vld[i]),
            .d_out (dat[i+1]),
            .v_out (vld[i+1])
        );
    end

    // Entry and exit in the same cycle cancel, keeping occ == popcount(vld).
    always_comb begin
        occ_d = occ_q;
        if (flush)
            occ_d = '0;
        else if (en)
            occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(vld[DEPTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occ_q <= '0;
        else
            occ_q <= occ_d;
    end

    assign q         = dat[DEPTH];
    assign q_valid   = vld[DEPTH];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed-vector bench: a DEPTH=4 and a DEPTH=1 instance share stimulus.
module tb_dff_pipeline;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic       d_valid = 1'b0;
    logic [7:0] d = 8'h00;

    logic [7:0] q4, q1;
    logic       qv4, qv1;
    logic [2:0] occ4;
    logic [0:0] occ1;

    int nvec = 0;
    int nerr = 0;

    localparam logic [7:0] RV4 = 8'hC3;
    localparam logic [7:0] RV1 = 8'h3C;

    dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q4), .q_valid(qv4), .occupancy(occ4)
    );

    dff_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .occupancy(occ1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs away from the edge, then settle 1 time unit past the edge.
    task automatic step(input logic e, input logic f, input logic v, input logic [7:0] x);
        en = e; flush = f; d_valid = v; d = x;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] b_d   [8] = '{8'hB1, 8'h00, 8'hB3, 8'hB4, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       b_v   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] b_q   [8] = '{8'h00, 8'h00, 8'h00, 8'hB1, 8'h00, 8'hB3, 8'hB4, 8'h00};
    logic       b_qv  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] b_occ [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Async reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_q4",   32'(q4),   32'(RV4));
        chk("rst_qv4",  32'(qv4),  32'd0);
        chk("rst_occ4", 32'(occ4), 32'd0);
        chk("rst_q1",   32'(q1),   32'(RV1));
        chk("rst_qv1",  32'(qv1),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency: single item appears on exactly the 4th edge
        step(1'b1, 1'b0, 1'b1, 8'hA5);
        chk("lat_occ_e1", 32'(occ4), 32'd1);
        chk("lat_qv_e1",  32'(qv4),  32'd0);
        chk("lat_q_e1",   32'(q4),   32'(RV4));
        chk("d1_q_e1",    32'(q1),   32'hA5);
        chk("d1_occ_e1",  32'(occ1), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("lat_occ_e2", 32'(occ4), 32'd1);
        chk("lat_qv_e2",  32'(qv4),  32'd0);
        chk("d1_qv_e2",   32'(qv1),  32'd0);
        chk("d1_occ_e2",  32'(occ1), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("lat_occ_e3", 32'(occ4), 32'd1);
        chk("lat_qv_e3",  32'(qv4),  32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("lat_occ_e4", 32'(occ4), 32'd1);
        chk("lat_qv_e4",  32'(qv4),  32'd1);
        chk("lat_q_e4",   32'(q4),   32'hA5);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("lat_occ_e5", 32'(occ4), 32'd0);
        chk("lat_qv_e5",  32'(qv4),  32'd0);

        // Full stream 0x01..0x08
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'(k));
            chk("strm_occ", 32'(occ4), (k < 4) ? 32'(k) : 32'd4);
            chk("strm_qv",  32'(qv4),  (k >= 4) ? 32'd1 : 32'd0);
            if (k >= 4) chk("strm_q", 32'(q4), 32'(k - 3));
            chk("strm_q1",   32'(q1),   32'(k));
            chk("strm_occ1", 32'(occ1), 32'd1);
        end
        for (int j = 1; j <= 4; j++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("drain_occ", 32'(occ4), 32'(4 - j));
            chk("drain_qv",  32'(qv4),  (j < 4) ? 32'd1 : 32'd0);
            if (j < 4) chk("drain_q", 32'(q4), 32'(5 + j));
        end

        // Stall with 0x11, 0x22 in flight; d_valid pulse during stall is dropped
        step(1'b1, 1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b0, 1'b1, 8'h22);
        chk("stall_pre_occ", 32'(occ4), 32'd2);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b0, 1'b1, 8'h99);
            chk("stall_occ", 32'(occ4), 32'd2);
            chk("stall_qv",  32'(qv4),  32'd0);
            chk("stall_q",   32'(q4),   32'h00);
            chk("stall_q1",  32'(q1),   32'h22);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("res_occ_c", 32'(occ4), 32'd2);
        chk("res_qv_c",  32'(qv4),  32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("res_q_d",   32'(q4),   32'h11);
        chk("res_qv_d",  32'(qv4),  32'd1);
        chk("res_occ_d", 32'(occ4), 32'd2);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("res_q_e",   32'(q4),   32'h22);
        chk("res_qv_e",  32'(qv4),  32'd1);
        chk("res_occ_e", 32'(occ4), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("res_qv_f",  32'(qv4),  32'd0);
        chk("res_occ_f", 32'(occ4), 32'd0);

        // Bubbles: valid 1,0,1,1,0 then idle
        for (int b = 0; b < 8; b++) begin
            step(1'b1, 1'b0, b_v[b], (b == 4) ? 8'hB5 : ((b == 1) ? 8'hB2 : b_d[b]));
            chk("bub_occ", 32'(occ4), 32'(b_occ[b]));
            chk("bub_qv",  32'(qv4),  32'(b_qv[b]));
            chk("bub_q",   32'(q4),   (b == 4) ? 32'hB2 : ((b == 7) ? 32'hB5 : 32'(b_q[b])));
        end

        // Flush at occupancy 3, with en=0 and d_valid=1
        step(1'b1, 1'b0, 1'b1, 8'hD1);
        step(1'b1, 1'b0, 1'b1, 8'hD2);
        step(1'b1, 1'b0, 1'b1, 8'hD3);
        chk("fl_pre_occ", 32'(occ4), 32'd3);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("fl_occ",  32'(occ4), 32'd0);
        chk("fl_qv",   32'(qv4),  32'd0);
        chk("fl_qv1",  32'(qv1),  32'd0);
        chk("fl_occ1", 32'(occ1), 32'd0);
        chk("fl_q1",   32'(q1),   32'hD3);
        for (int j = 1; j <= 4; j++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("postfl_qv",  32'(qv4),  32'd0);
            chk("postfl_occ", 32'(occ4), 32'd0);
            if (j == 1) chk("postfl_q_held", 32'(q4), 32'hD1);
        end

        // Async reset mid-stream with occupancy 4
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 8'(8'h41 + k));
        chk("ar_pre_occ", 32'(occ4), 32'd4);
        chk("ar_pre_qv",  32'(qv4),  32'd1);
        #3 rst = 1'b1;
        #1;
        chk("ar_q4",   32'(q4),   32'(RV4));
        chk("ar_qv4",  32'(qv4),  32'd0);
        chk("ar_occ4", 32'(occ4), 32'd0);
        chk("ar_q1",   32'(q1),   32'(RV1));
        chk("ar_occ1", 32'(occ1), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("post_ar_qv",  32'(qv4),  32'd0);
            chk("post_ar_occ", 32'(occ4), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dff_pipeline.md
Name: dff_pipeline

Overview:
Parametrised successor to the single-bit D flip-flop. It is a DEPTH-stage, WIDTH-bit registered delay line with a per-stage valid bit, a global stall enable, a synchronous flush and a registered occupancy count. It is used wherever datapaths need fixed-latency alignment with bubble tracking, for example to match one pipeline branch's latency to another.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages, which is also the latency in enabled cycles (>=1)
RESET_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset

Ports:
clk  input  1  rising-edge clock; the block uses this single clock
rst  input  1  asynchronous, active-high reset
en  input  1  advance enable; 0 stalls the whole pipeline
flush  input  1  synchronous flush of all valid bits; takes priority over en
d  input  WIDTH  data in
d_valid  input  1  d carries a valid item this cycle
q  output  WIDTH  data out (last stage)
q_valid  output  1  valid bit of last stage
occupancy  output  $clog2(DEPTH+1)  number of stages currently holding valid items

Behaviour:
- Reset: asserting rst immediately, without waiting for clk, sets every data stage to RESET_VAL, every valid bit to 0 and occupancy to 0. The outputs are q=RESET_VAL, q_valid=0, occupancy=0.
- Deasserting rst takes effect at the next rising clk edge. Reset asserted mid-stream discards all in-flight items.
- Advance (en=1, flush=0) on each rising edge:
  - stage[0] captures d and vld[0] captures d_valid;
  - stage[i] takes stage[i-1] and vld[i] takes vld[i-1] for i=1..DEPTH-1.
  - q=stage[DEPTH-1] and q_valid=vld[DEPTH-1]. Latency is exactly DEPTH enabled edges.
- Data registers advance whenever en=1, regardless of valid. When q_valid=0, the value on q is defined (the shifted data) but is not meaningful.
- Stall (en=0, flush=0): all data, valid and occupancy registers hold. Inputs d and d_valid are ignored, so an item presented during a stall is lost. Upstream must hold it.
- Flush (flush=1, regardless of en):
  - all vld[] clear and occupancy becomes 0 on the next edge;
  - data registers hold;
  - d_valid on that cycle is discarded.
- Occupancy update when advancing: occupancy_next = occupancy + d_valid - vld[DEPTH-1].
  - A simultaneous entry and exit leaves occupancy unchanged.
  - Occupancy is never less than 0 and never more than DEPTH by construction.
  - Invariant: occupancy == popcount(vld[]) at every edge.
- DEPTH=1 degenerates to a single D flip-flop with a valid bit, enable, flush and a 1-bit occupancy equal to q_valid.
- All outputs are driven directly from registers, with no combinational path from input to output.

Decomposition:
- Package dff_pkg holds:
  - DFF_DEF_WIDTH=8 and DFF_DEF_DEPTH=4;
  - the function occ_width(depth)=$clog2(depth+1).
- Sub-module dff_stage holds one WIDTH-bit data register plus its valid bit, with inputs clk, rst, en, flush, d_in, v_in and outputs d_out, v_out.
- dff_pipeline instantiates DEPTH copies of dff_stage in a generate loop and owns the occupancy counter.

Test Plan:
- Latency (WIDTH=8, DEPTH=4):
  - Stimulus: rst pulse, then en=1 with d=0xA5, d_valid=1 for one cycle.
  - Required: q=0xA5 with q_valid=1 on exactly the 4th edge; occupancy steps 1,1,1,1 and then 0.
- Full stream:
  - Stimulus: d=0x01..0x08 valid on consecutive cycles.
  - Required: q emits 0x01..0x08 in order starting at edge 4; occupancy reads 1,2,3,4 and then stays at 4 until the inputs stop.
- Stall:
  - Stimulus: with 0x11,0x22 in flight, hold en=0 for 3 cycles.
  - Required: q, q_valid and occupancy are frozen, and a d_valid=1 pulse during the stall is not captured.
  - On resume, 0x11 and 0x22 exit on the expected edges.
- Bubbles:
  - Stimulus: valid pattern 1,0,1,1,0.
  - Required: q_valid reproduces 1,0,1,1,0 delayed by 4, and occupancy always equals the popcount of valid bits in flight.
- Flush:
  - Stimulus: occupancy=3, then flush=1 with en=0 and d_valid=1.
  - Required: next edge gives q_valid=0 and occupancy=0, and nothing emerges afterwards.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges while occupancy=4.
  - Required: q=RESET_VAL, q_valid=0 and occupancy=0 immediately, before the next clk edge.
  - Stimulus: run the same bench with DEPTH=1.
  - Required: q follows d one edge later and occupancy equals q_valid.
